// File: rtl/seq_mult_ctrl_pkg.sv
// Shared types and sizing for the sequential shift-add multiplier.
package seq_mult_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_mult_ctrl_counter.sv
// Iteration counter for the shift-add loop: synchronous clear wins over increment.
module mult_bit_counter
  import seq_mult_ctrl_pkg::*;
#(
  parameter int CNT_W_P = CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [CNT_W_P-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + 1'b1;
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential unsigned shift-add multiplier with start/busy/done handshake;
// one WIDTH x WIDTH product every WIDTH+1 cycles.
module seq_mult_ctrl
  import seq_mult_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state, state_next;
  logic [WIDTH:0]     acc, sum;
  logic [WIDTH-1:0]   mcand_r, mult_r;
  logic [2*WIDTH:0]   shifted;
  logic [CW-1:0]      count;
  logic               accept, last, cnt_clr, cnt_inc;

  // NOTE: every signal driven here gets a default first so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    sum        = mult_r[0] ? (acc + {1'b0, mcand_r}) : acc;
    shifted    = {sum, mult_r} >> 1;
    last       = (state == CALC) && (count == CW'(WIDTH - 1));
    case (state)
      IDLE: if (start) begin
        accept     = 1'b1;
        state_next = CALC;
      end
      CALC: if (last) state_next = DONE;
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = CALC;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    cnt_clr = accept | last;
    cnt_inc = (state == CALC);
  end

  // busy/done come straight off flops so no input reaches them combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == CALC);
      done  <= (state_next == DONE);
    end
  end

  // NOTE: datapath registers are plain flops, not a memory array, so they
  // take the async reset and an aborted operation leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      mcand_r <= '0;
      mult_r  <= '0;
      out     <= '0;
    end else if (accept) begin
      acc     <= '0;
      mcand_r <= A;
      mult_r  <= B;
    end else if (state == CALC) begin
      acc    <= shifted[2*WIDTH:WIDTH];
      mult_r <= shifted[WIDTH-1:0];
      if (last) out <= shifted[2*WIDTH-1:0];
    end
  end

  mult_bit_counter #(.CNT_W_P(CW)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (count)
  );

endmodule
